// File: rtl/subtractn_serial.sv
// rtl/subtractn_serial.sv - serial X - Y - borrowin, one k-bit slice per clock
// Optional Zero result flag: define SUBTRACTN_ZERO_FLAG_EN
module subtractn_serial #(
    parameter int n = 32,
    parameter int k = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Start,
    input  logic         borrowin,
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    input  logic         Ack,
    output logic         Ready,
    output logic         Done,
    output logic [n-1:0] S,
    output logic         borrowout,
    output logic         overflow
`ifdef SUBTRACTN_ZERO_FLAG_EN
    ,
    output logic         Zero
`endif
);

    localparam int SLICES = n / k;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  slice_cnt;
    logic [n-1:0]   x_lat;
    logic [n-1:0]   y_lat;
    logic [n-1:0]   work;
    logic           borrow;

    logic [k-1:0]   x_slice;
    logic [k-1:0]   y_slice;
    logic [k-1:0]   diff_slice;
    logic           borrow_next;
    logic [n-1:0]   work_next;
    logic           overflow_next;
    int             slice_base;

    // Current slice difference; work_next already holds it so the final
    // cycle can load S without an extra edge.
    always_comb begin
        slice_base  = int'(slice_cnt) * k;
        x_slice     = x_lat[slice_base +: k];
        y_slice     = y_lat[slice_base +: k];
        {borrow_next, diff_slice} = {1'b0, x_slice} - {1'b0, y_slice}
                                    - {{k{1'b0}}, borrow};
        work_next   = work;
        work_next[slice_base +: k] = diff_slice;
        overflow_next = (x_lat[n-1] ^ y_lat[n-1]) & (work_next[n-1] ^ x_lat[n-1]);
    end

    assign Ready = (state == IDLE);
    assign Done  = (state == DONE);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            slice_cnt <= '0;
            x_lat     <= '0;
            y_lat     <= '0;
            work      <= '0;
            borrow    <= 1'b0;
            S         <= '0;
            borrowout <= 1'b0;
            overflow  <= 1'b0;
`ifdef SUBTRACTN_ZERO_FLAG_EN
            Zero      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        x_lat     <= X;
                        y_lat     <= Y;
                        borrow    <= borrowin;
                        slice_cnt <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    work      <= work_next;
                    borrow    <= borrow_next;
                    slice_cnt <= slice_cnt + CW'(1);
                    if (slice_cnt == LAST_SLICE) begin
                        slice_cnt <= '0;
                        S         <= work_next;
                        borrowout <= borrow_next;
                        overflow  <= overflow_next;
`ifdef SUBTRACTN_ZERO_FLAG_EN
                        Zero      <= (work_next == '0);
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Start is deliberately not looked at here, even with Ack.
                    if (Ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subtractn_serial.sv
// tb/tb_subtractn_serial.sv - scoreboard bench for subtractn_serial (n=32, k=4)
module tb_subtractn_serial;

    localparam int N = 32;
    localparam int K = 4;
    localparam int LATENCY = N / K;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          Start;
    logic          borrowin;
    logic [N-1:0]  X;
    logic [N-1:0]  Y;
    logic          Ack;
    logic          Ready;
    logic          Done;
    logic [N-1:0]  S;
    logic          borrowout;
    logic          overflow;
`ifdef SUBTRACTN_ZERO_FLAG_EN
    logic          Zero;
`endif

    typedef struct {
        logic [N-1:0] s;
        logic         bo;
        logic         ov;
        logic         z;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    subtractn_serial #(.n(N), .k(K)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Start     (Start),
        .borrowin  (borrowin),
        .X         (X),
        .Y         (Y),
        .Ack       (Ack),
        .Ready     (Ready),
        .Done      (Done),
        .S         (S),
        .borrowout (borrowout),
        .overflow  (overflow)
`ifdef SUBTRACTN_ZERO_FLAG_EN
        ,
        .Zero      (Zero)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
        exp_t e;
        logic [N:0] wide;
        wide  = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
        e.s   = wide[N-1:0];
        e.bo  = ({1'b0, x} < ({1'b0, y} + {{N{1'b0}}, bi}));
        e.ov  = (x[N-1] ^ y[N-1]) & (e.s[N-1] ^ x[N-1]);
        e.z   = (e.s == '0);
        return e;
    endfunction

    // Drives one request, scrambles inputs after the sampling edge, checks
    // latency and result, then holds DONE for hold_cycles before Ack.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic bi, input int hold_cycles);
        int   edges;
        exp_t e;
        logic [N-1:0] s_held;
        logic bo_held;
        logic ov_held;
        @(negedge Clock);
        check("ready_before_start", Ready, 1);
        X = x; Y = y; borrowin = bi; Start = 1'b1;
        exp_q.push_back(model(x, y, bi));
        @(posedge Clock);
        #1;
        Start = 1'b0;
        X = $urandom; Y = $urandom; borrowin = 1'($urandom_range(0, 1));
        edges = 0;
        while (!Done && edges < 3 * LATENCY) begin
            @(posedge Clock);
            #1;
            edges++;
        end
        check("latency", edges, LATENCY);
        check("ready_in_done", Ready, 0);
        if (exp_q.size() == 0) begin
            check("sb_empty_at_done", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("S", S, e.s);
            check("borrowout", borrowout, e.bo);
            check("overflow", overflow, e.ov);
`ifdef SUBTRACTN_ZERO_FLAG_EN
            check("zero", Zero, e.z);
`endif
        end
        s_held = S; bo_held = borrowout; ov_held = overflow;
        for (int i = 0; i < hold_cycles; i++) begin
            X = $urandom; Y = $urandom; Start = 1'($urandom_range(0, 1));
            @(posedge Clock);
            #1;
            check("hold_S", S, s_held);
            check("hold_bo", borrowout, bo_held);
            check("hold_ov", overflow, ov_held);
            check("hold_done", Done, 1);
            check("hold_ready", Ready, 0);
        end
        // Start alongside Ack must not launch a new operation.
        Ack = 1'b1; Start = 1'b1;
        @(posedge Clock);
        #1;
        Ack = 1'b0; Start = 1'b0;
        check("ack_ready", Ready, 1);
        check("ack_done", Done, 0);
        check("ack_S_kept", S, s_held);
    endtask

    initial begin
        exp_t e;
        Resetn = 1'b0; Start = 1'b0; borrowin = 1'b0; X = '0; Y = '0; Ack = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_ready", Ready, 1);
        check("rst_done", Done, 0);
        check("rst_S", S, 0);
        check("rst_bo", borrowout, 0);
        check("rst_ov", overflow, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        // Ack outside DONE is ignored.
        Ack = 1'b1;
        @(posedge Clock);
        #1;
        Ack = 1'b0;
        check("ack_idle_ready", Ready, 1);

        run_op(32'd5, 32'd3, 1'b0, 0);
        run_op(32'd0, 32'd1, 1'b0, 0);
        run_op(32'h8000_0000, 32'd1, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5);
        run_op(32'd5, 32'd5, 1'b1, 0);
        run_op(32'd5, 32'd5, 1'b0, 1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        for (int i = 0; i < 6; i++)
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), i % 3);

        // Abort in the middle of RUN.
        @(negedge Clock);
        X = 32'h1234_5678; Y = 32'h0000_0001; borrowin = 1'b0; Start = 1'b1;
        exp_q.push_back(model(X, Y, borrowin));
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (4) @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        check("abort_ready", Ready, 1);
        check("abort_done", Done, 0);
        check("abort_S", S, 0);
        check("abort_bo", borrowout, 0);
        check("abort_ov", overflow, 0);
        e = exp_q.pop_back();
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 2 * LATENCY; i++) begin
            @(posedge Clock);
            #1;
            check("no_done_after_abort", Done, 0);
        end
        check("ready_after_abort", Ready, 1);

        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/subtractn_serial.md
SUBTRACTN_SERIAL -- requirements
Module: subtractn_serial

Interface
REQ-001 SHALL have parameter n, default 32, operand and result width.
REQ-002 SHALL have parameter k, default 4, slice width processed per cycle; n SHALL be an integer multiple of k.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Resetn, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port Start, input, 1, request to begin a subtraction.
REQ-006 SHALL have port borrowin, input, 1, borrow into the LSB slice.
REQ-007 SHALL have port X, input, n, minuend.
REQ-008 SHALL have port Y, input, n, subtrahend.
REQ-009 SHALL have port Ack, input, 1, consumer acknowledge of the result.
REQ-010 SHALL have port Ready, output, 1, high when a new Start will be accepted.
REQ-011 SHALL have port Done, output, 1, high while the result is valid.
REQ-012 SHALL have port S, output, n, difference X - Y - borrowin modulo 2^n.
REQ-013 SHALL have port borrowout, output, 1, borrow out of the MSB.
REQ-014 SHALL have port overflow, output, 1, two's-complement overflow.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL assert Ready only in IDLE and Done only in DONE; both outputs SHALL be decoded from registered state.
REQ-017 In IDLE with Start=1, SHALL latch X, Y and borrowin, clear the slice counter, and enter RUN.
REQ-018 In RUN, SHALL process one k-bit slice per cycle, LSB slice first: {b', d} = Xslice - Yslice - b, where b starts as the latched borrowin.
REQ-019 SHALL store each d in a working register and propagate b' to the next slice.
REQ-020 SHALL increment the slice counter every RUN cycle and leave RUN after n/k slices.
REQ-021 On leaving RUN, SHALL load S, borrowout and overflow from the working register and final borrow, and enter DONE.
REQ-022 Latency: Done SHALL rise at the (n/k)-th rising edge after the edge that samples Start (8 edges for n=32, k=4).
REQ-023 borrowout SHALL be 1 exactly when unsigned X < Y + borrowin.
REQ-024 overflow SHALL equal (X[n-1] XOR Y[n-1]) AND (S[n-1] XOR X[n-1]).
REQ-025 S, borrowout and overflow SHALL change only on entry to DONE or on reset; they SHALL be held until the next entry to DONE.
REQ-026 Changes on X, Y and borrowin after the Start-sampling edge SHALL NOT affect the result.
REQ-027 In DONE with Ack=1, SHALL return to IDLE on the next edge; in DONE with Ack=0, SHALL stay in DONE.
REQ-028 Start SHALL be ignored in RUN and DONE; a Start in the same cycle as an Ack in DONE SHALL NOT be accepted.
REQ-029 Ack outside DONE SHALL be ignored.

Reset
REQ-030 Resetn=0 SHALL asynchronously force IDLE, clear the slice counter and the working register, and set S=0, borrowout=0, overflow=0, Done=0, Ready=1.
REQ-031 Reset during RUN or DONE SHALL abort the operation; no Done pulse SHALL follow release of reset.

Configuration
REQ-032 With macro SUBTRACTN_ZERO_FLAG_EN defined, SHALL add output port Zero, 1 bit, registered, set on entry to DONE to (S == 0), and reset to 0.
REQ-033 Without SUBTRACTN_ZERO_FLAG_EN, port Zero and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification (n=32, k=4)
REQ-034 X=5, Y=3, borrowin=0, Start for 1 cycle -> Done at the 8th edge, S=0x00000002, borrowout=0, overflow=0.
REQ-035 X=0, Y=1 -> S=0xFFFFFFFF, borrowout=1, overflow=0; X=0x80000000, Y=1 -> S=0x7FFFFFFF, borrowout=0, overflow=1.
REQ-036 X=0x7FFFFFFF, Y=0xFFFFFFFF -> S=0x80000000, borrowout=1, overflow=1; X=Y=5, borrowin=1 -> S=0xFFFFFFFF, borrowout=1; with the macro defined, X=Y=5, borrowin=0 -> Zero=1.
REQ-037 Hold Ack=0 for 5 cycles in DONE while X, Y change and Start pulses -> S, borrowout and overflow stable, Done held high, Ready=0; then Ack=1 -> IDLE and Ready=1 next cycle.
REQ-038 Resetn low at slice 4 of RUN -> all outputs 0 and Ready=1 immediately; after release, no Done appears until a new Start.
